// File: rtl/j17_pkg.sv
// rtl/j17_pkg.sv - shared pcControl codes, sequencer state encoding and flag layout
// Purpose: definitions shared by the control unit and the program-counter sequencer.
// Contents: pcControl code localparams, run/halt state enum, latched flag struct.
package j17_pkg;

  localparam int unsigned PC_CTL_W = 5;

  localparam logic [PC_CTL_W-1:0] PC_SEQ = 5'd0;
  localparam logic [PC_CTL_W-1:0] PC_JE  = 5'd1;
  localparam logic [PC_CTL_W-1:0] PC_JB  = 5'd2;
  localparam logic [PC_CTL_W-1:0] PC_JA  = 5'd3;
  localparam logic [PC_CTL_W-1:0] PC_JNE = 5'd4;
  localparam logic [PC_CTL_W-1:0] PC_JBE = 5'd5;
  localparam logic [PC_CTL_W-1:0] PC_JAE = 5'd6;
  localparam logic [PC_CTL_W-1:0] PC_JNZ = 5'd7;
  localparam logic [PC_CTL_W-1:0] PC_JZ  = 5'd8;
  localparam logic [PC_CTL_W-1:0] PC_JMP = 5'd9;
  localparam logic [PC_CTL_W-1:0] PC_HLT = 5'd10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_t;

  // Latched ALU comparison flags, packed as {eq, lt, gt, zero}.
  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
    logic zero;
  } flags_t;

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// rtl/pc_sequencer_branch_cond.sv - branch condition evaluation on latched flags
// Purpose: decide whether the current pcControl code is a taken jump.
// Ports:
//   pcControl  in  5       control-unit code
//   flags      in  flags_t latched {eq, lt, gt, zero}
//   take       out 1       1 when the code is a jump whose condition holds
module branch_cond
  import j17_pkg::*;
(
  input  logic [PC_CTL_W-1:0] pcControl,
  input  flags_t              flags,
  output logic                take
);

  always_comb begin
    take = 1'b0;
    case (pcControl)
      PC_JE:   take = flags.eq;
      PC_JB:   take = flags.lt;
      PC_JA:   take = flags.gt;
      PC_JNE:  take = ~flags.eq;
      PC_JBE:  take = flags.lt | flags.eq;
      PC_JAE:  take = flags.gt | flags.eq;
      PC_JNZ:  take = ~flags.zero;
      PC_JZ:   take = flags.zero;
      PC_JMP:  take = 1'b1;
      // Sequential, HLT and unassigned codes never branch.
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with flag register, run/halt FSM and retire counter
// Purpose: produce the next instruction address from the control unit's pcControl code.
// Ports:
//   clock      in  1       rising-edge clock
//   reset      in  1       synchronous active-high reset
//   pcControl  in  5       sequencing code (11-31 behave as sequential)
//   target     in  ADDR_W  absolute branch target
//   alu_eq/lt/gt/zero in 1 live ALU flags
//   flag_we    in  1       latch ALU flags this cycle
//   stall      in  1       hold all state this cycle
//   resume     in  1       leave HALT
//   pc         out ADDR_W  current instruction address
//   halted     out 1       high while in HALT
//   taken      out 1       pulse after a taken jump
//   retired    out CNT_W   retired-instruction count
module pc_sequencer
  import j17_pkg::*;
#(
  parameter int unsigned           ADDR_W   = 21,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter int unsigned           CNT_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_CTL_W-1:0] pcControl,
  input  logic [ADDR_W-1:0]   target,
  input  logic                alu_eq,
  input  logic                alu_lt,
  input  logic                alu_gt,
  input  logic                alu_zero,
  input  logic                flag_we,
  input  logic                stall,
  input  logic                resume,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic                taken,
  output logic [CNT_W-1:0]    retired
);

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_pc;
  flags_t            r_flags;
  logic              r_halted;
  logic              r_taken;
  logic [CNT_W-1:0]  r_retired;

  seq_state_t        w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  flags_t            w_flags_nxt;
  logic              w_halted_nxt;
  logic              w_taken_nxt;
  logic [CNT_W-1:0]  w_retired_nxt;
  logic              w_take;

  // Conditions look only at the registered flags, so a flag write in the
  // same cycle as a jump affects the next instruction, not this one.
  branch_cond u_branch_cond (
    .pcControl (pcControl),
    .flags     (r_flags),
    .take      (w_take)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_flags_nxt   = r_flags;
    w_halted_nxt  = r_halted;
    w_taken_nxt   = 1'b0;
    w_retired_nxt = r_retired;

    if (!stall) begin
      case (r_state)
        ST_RUN: begin
          // Every non-stalled RUN cycle retires one instruction, HLT included.
          w_retired_nxt = r_retired + CNT_W'(1);
          if (flag_we) begin
            w_flags_nxt = '{eq: alu_eq, lt: alu_lt, gt: alu_gt, zero: alu_zero};
          end
          if (pcControl == PC_HLT) begin
            w_state_nxt  = ST_HALT;
            w_halted_nxt = 1'b1;
          end else if (w_take) begin
            w_pc_nxt    = target;
            w_taken_nxt = 1'b1;
          end else begin
            w_pc_nxt = r_pc + ADDR_W'(1);
          end
        end
        ST_HALT: begin
          if (resume) begin
            w_pc_nxt     = r_pc + ADDR_W'(1);
            w_state_nxt  = ST_RUN;
            w_halted_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt  = ST_RUN;
          w_halted_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_flags   <= '0;
      r_halted  <= 1'b0;
      r_taken   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_flags   <= w_flags_nxt;
      r_halted  <= w_halted_nxt;
      r_taken   <= w_taken_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  assign pc      = r_pc;
  assign halted  = r_halted;
  assign taken   = r_taken;
  assign retired = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard testbench for pc_sequencer
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic [4:0]  pcControl;
  logic [20:0] target;
  logic        alu_eq, alu_lt, alu_gt, alu_zero;
  logic        flag_we, stall, resume;
  logic [20:0] pc;
  logic        halted, taken;
  logic [31:0] retired;

  typedef struct {
    int          idx;
    logic [20:0] pc;
    logic        halted;
    logic        taken;
    logic [31:0] retired;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_idx = 0;

  pc_sequencer #(.ADDR_W(21), .RESET_PC(21'd0), .CNT_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .pcControl (pcControl),
    .target    (target),
    .alu_eq    (alu_eq),
    .alu_lt    (alu_lt),
    .alu_gt    (alu_gt),
    .alu_zero  (alu_zero),
    .flag_we   (flag_we),
    .stall     (stall),
    .resume    (resume),
    .pc        (pc),
    .halted    (halted),
    .taken     (taken),
    .retired   (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // fl is {eq, lt, gt, zero}; expected values describe the outputs after the
  // edge that consumes this vector.
  task automatic step(input logic rst, input logic [4:0] ctl, input logic [20:0] tgt,
                      input logic [3:0] fl, input logic fwe, input logic stl, input logic res,
                      input logic [20:0] epc, input logic eh, input logic et,
                      input logic [31:0] eret);
    exp_t e;
    @(posedge clock);
    #2;
    reset     = rst;
    pcControl = ctl;
    target    = tgt;
    alu_eq    = fl[3];
    alu_lt    = fl[2];
    alu_gt    = fl[1];
    alu_zero  = fl[0];
    flag_we   = fwe;
    stall     = stl;
    resume    = res;
    step_idx++;
    e.idx = step_idx; e.pc = epc; e.halted = eh; e.taken = et; e.retired = eret;
    exp_q.push_back(e);
  endtask

  // Monitor: one output sample per edge, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (pc !== e.pc) begin
          errors++;
          $display("FAIL step %0d pc: got %h expected %h", e.idx, pc, e.pc);
        end
        if (halted !== e.halted) begin
          errors++;
          $display("FAIL step %0d halted: got %b expected %b", e.idx, halted, e.halted);
        end
        if (taken !== e.taken) begin
          errors++;
          $display("FAIL step %0d taken: got %b expected %b", e.idx, taken, e.taken);
        end
        if (retired !== e.retired) begin
          errors++;
          $display("FAIL step %0d retired: got %0d expected %0d", e.idx, retired, e.retired);
        end
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1; pcControl = 5'd0; target = '0;
    alu_eq = 0; alu_lt = 0; alu_gt = 0; alu_zero = 0;
    flag_we = 0; stall = 0; resume = 0;

    //    rst ctl    target       {e,l,g,z} fwe stl res  pc          h  t  ret
    step(1, 5'd0,  21'h0,       4'b0000, 0, 0, 0,  21'h0,       0, 0, 0);
    step(1, 5'd0,  21'h0,       4'b0000, 0, 0, 0,  21'h0,       0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step(0, 5'd0, 21'h0,      4'b0000, 0, 0, 0,  21'(i),      0, 0, 32'(i));
    // JE taken after eq latched, then JNE not taken with eq latched
    step(0, 5'd0,  21'h0,       4'b1000, 1, 0, 0,  21'h6,       0, 0, 6);
    step(0, 5'd1,  21'h1234,    4'b0000, 0, 0, 0,  21'h1234,    0, 1, 7);
    step(0, 5'd0,  21'h0,       4'b0000, 0, 0, 0,  21'h1235,    0, 0, 8);
    step(0, 5'd0,  21'h0,       4'b1000, 1, 0, 0,  21'h1236,    0, 0, 9);
    step(0, 5'd4,  21'h0555,    4'b0000, 0, 0, 0,  21'h1237,    0, 0, 10);
    // lt only: JBE taken, JAE/JA not, JB taken
    step(0, 5'd0,  21'h0,       4'b0100, 1, 0, 0,  21'h1238,    0, 0, 11);
    step(0, 5'd5,  21'h100,     4'b0000, 0, 0, 0,  21'h100,     0, 1, 12);
    step(0, 5'd6,  21'h200,     4'b0000, 0, 0, 0,  21'h101,     0, 0, 13);
    step(0, 5'd3,  21'h300,     4'b0000, 0, 0, 0,  21'h102,     0, 0, 14);
    step(0, 5'd2,  21'h400,     4'b0000, 0, 0, 0,  21'h400,     0, 1, 15);
    // same-cycle hazard: JZ with flag_we uses old flags
    step(0, 5'd0,  21'h0,       4'b0000, 1, 0, 0,  21'h401,     0, 0, 16);
    step(0, 5'd8,  21'h500,     4'b0001, 1, 0, 0,  21'h402,     0, 0, 17);
    step(0, 5'd8,  21'h500,     4'b0000, 0, 0, 0,  21'h500,     0, 1, 18);
    step(0, 5'd7,  21'h600,     4'b0000, 0, 0, 0,  21'h501,     0, 0, 19);
    step(0, 5'd15, 21'h700,     4'b0000, 0, 0, 0,  21'h502,     0, 0, 20);
    step(0, 5'd9,  21'h7,       4'b0000, 0, 0, 0,  21'h7,       0, 1, 21);
    // HLT at pc 7 with a flag write (eq only), then 10 halted cycles
    step(0, 5'd10, 21'h0,       4'b1000, 1, 0, 0,  21'h7,       1, 0, 22);
    for (int i = 0; i < 10; i++)
      step(0, 5'd9, 21'h99,     4'b0001, 1, 0, 0,  21'h7,       1, 0, 22);
    step(0, 5'd0,  21'h0,       4'b0000, 0, 0, 1,  21'h8,       0, 0, 22);
    step(0, 5'd1,  21'h40,      4'b0000, 0, 0, 0,  21'h40,      0, 1, 23);
    step(0, 5'd8,  21'h50,      4'b0000, 0, 0, 0,  21'h41,      0, 0, 24);
    // wrap at top of address space with a stall in between
    step(0, 5'd9,  21'h1FFFFE,  4'b0000, 0, 0, 0,  21'h1FFFFE,  0, 1, 25);
    step(0, 5'd0,  21'h0,       4'b0000, 0, 0, 0,  21'h1FFFFF,  0, 0, 26);
    step(0, 5'd9,  21'h10,      4'b0001, 1, 1, 0,  21'h1FFFFF,  0, 0, 26);
    step(0, 5'd10, 21'h0,       4'b0001, 1, 1, 0,  21'h1FFFFF,  0, 0, 26);
    step(0, 5'd0,  21'h0,       4'b0001, 1, 1, 0,  21'h1FFFFF,  0, 0, 26);
    step(0, 5'd0,  21'h0,       4'b0000, 0, 0, 0,  21'h0,       0, 0, 27);
    step(0, 5'd8,  21'h60,      4'b0000, 0, 0, 0,  21'h1,       0, 0, 28);
    // reset while halted and stalled clears everything including flags
    step(0, 5'd10, 21'h0,       4'b0000, 0, 0, 0,  21'h1,       1, 0, 29);
    step(0, 5'd0,  21'h0,       4'b0000, 0, 1, 1,  21'h1,       1, 0, 29);
    step(1, 5'd0,  21'h0,       4'b0000, 1, 1, 1,  21'h0,       0, 0, 0);
    step(0, 5'd1,  21'h70,      4'b0000, 0, 0, 0,  21'h1,       0, 0, 1);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clock);
      #2;
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that consumes the control unit's `pcControl` code, the decoded 21-bit branch target (`op2`) and the ALU comparison flags, and produces the next instruction address. It sits between the control unit and instruction memory. It owns the latched condition-flag register, the run/halt state machine and a retired-instruction counter.

## Interface
Parameters:
- `ADDR_W`, 21, PC and branch-target width; matches `op2`.
- `RESET_PC`, 0, PC value after reset.
- `CNT_W`, 32, retired-instruction counter width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pcControl`  in  5  code from the control unit: 0 sequential, 1 JE, 2 JB, 3 JA, 4 JNE, 5 JBE, 6 JAE, 7 JNZ, 8 JZ, 9 JMP, 10 HLT. Codes 11–31 are treated as 0.
- `target`  in  ADDR_W  absolute branch target (`op2`).
- `alu_eq`, `alu_lt`, `alu_gt`, `alu_zero`  in  1 each  combinational ALU flags for the current instruction.
- `flag_we`  in  1  latch the ALU flags into the flag register at the end of this cycle.
- `stall`  in  1  hold all state for this cycle.
- `resume`  in  1  leave HALT.
- `pc`  out  ADDR_W  registered current instruction address.
- `halted`  out  1  registered; high while in HALT.
- `taken`  out  1  registered; 1-cycle pulse when the previous update was a taken jump.
- `retired`  out  CNT_W  count of instructions completed.

## Operation
- Flag register `{eq, lt, gt, zero}`:
  - Reset value 0000.
  - Loaded from the `alu_*` inputs on an edge where `flag_we=1`, `stall=0` and the state is RUN.
- Branch conditions evaluate the latched flags, never the live `alu_*` inputs:
  - JE: eq. JB: lt. JA: gt. JNE: !eq.
  - JBE: lt|eq. JAE: gt|eq.
  - JNZ: !zero. JZ: zero. JMP: always.
- State machine has two states, RUN and HALT.
- RUN, `stall=0`:
  - Condition true: `pc<=target`, `taken<=1`, `retired+=1`.
  - Condition false, or code 0: `pc<=pc+1` (wraps modulo 2^ADDR_W), `taken<=0`, `retired+=1`.
  - HLT: `pc` holds, `retired+=1`, state goes to HALT, `halted<=1`, `taken<=0`.
- HALT, `stall=0`:
  - `resume=1`: `pc<=pc+1`, state goes to RUN, `halted<=0`.
  - Otherwise all state holds, `pcControl` is ignored and `taken<=0`.
- `stall=1` in either state: `pc`, the flags, the state, `retired` and `halted` all hold, and `taken<=0`. `resume` is ignored.
- `retired` wraps modulo 2^CNT_W.

## Timing
- Reset values: `pc=RESET_PC`, `halted=0`, `taken=0`, `retired=0`, flags 0000, state RUN.
- Reset overrides `stall`, `resume` and `flag_we`, including during HALT.
- Latency: the new `pc` is visible 1 cycle after the edge that samples `pcControl`.
- A jump in the same cycle as `flag_we=1` uses the old flags. The new flags apply from the next instruction onward.
- A flag write in the cycle `pcControl=HLT` is still performed.
- `target` is sampled only on the taken-jump edge. It does not need to be held afterwards.
- No combinational path from any input to any output.

## Structure
- Shared package `j17_pkg` holds:
  - the `pcControl` codes (`PC_SEQ`, `PC_JE` … `PC_JMP`, `PC_HLT`) as localparams, also imported by the control unit;
  - the state encoding `ST_RUN`, `ST_HALT`.
- One combinational sub-module, `branch_cond`: inputs `pcControl` and the latched flags, output `take`.
- The top level holds the PC register, flag register, FSM and counter.

## Test plan
- Reset, then 5 cycles of `pcControl=0` -> `pc` goes 0,1,2,3,4,5; `retired=5`; `taken` stays 0.
- `flag_we=1` with `alu_eq=1`, then next cycle JE with `target=0x1234` -> `pc=0x1234` and `taken` pulses for 1 cycle. Same sequence with JNE -> `pc` increments.
- Same-cycle hazard: flags 0000 latched, then JZ with `flag_we=1`, `alu_zero=1` -> not taken. A following JZ -> taken.
- HLT at `pc=7` -> `halted=1`, `pc` stays 7 for 10 cycles, `retired` frozen. `resume=1` -> `pc=8`, `halted=0`.
- `pc=0x1FFFFF` with code 0 -> `pc=0`. With `stall=1` for 3 cycles in the middle -> `pc` and `retired` unchanged during the stall.
- `reset` asserted while in HALT with `stall=1` -> next cycle `pc=RESET_PC`, `halted=0`, `retired=0`, flags cleared.
